// File: rtl/triangle_scheduler_if.sv
// triangle_scheduler_if: command input and rasterizer-side signals of the triangle scheduler.
// Rev 1.0
`default_nettype none

interface triangle_scheduler_if;
  logic         i_tri_valid;
  logic         o_tri_ready;
  logic [127:0] i_v1, i_v2, i_v3;
  logic [127:0] i_c1, i_c2, i_c3;
  logic         o_rast_start;
  logic [127:0] o_v1, o_v2, o_v3;
  logic [127:0] o_c1, o_c2, o_c3;
  logic         i_rast_idle;
  logic         i_rast_write;

  modport slave (
    input  i_tri_valid, i_v1, i_v2, i_v3, i_c1, i_c2, i_c3, i_rast_idle, i_rast_write,
    output o_tri_ready, o_rast_start, o_v1, o_v2, o_v3, o_c1, o_c2, o_c3
  );

  modport master (
    output i_tri_valid, i_v1, i_v2, i_v3, i_c1, i_c2, i_c3, i_rast_idle, i_rast_write,
    input  o_tri_ready, o_rast_start, o_v1, o_v2, o_v3, o_c1, o_c2, o_c3
  );
endinterface

`default_nettype wire

// File: rtl/triangle_scheduler.sv
// triangle_scheduler: FIFO-buffered triangle issue to the rasterizer with completion tracking and stats.
// Rev 1.0
`default_nettype none

module triangle_scheduler #(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  wire logic                   i_clk,
  input  wire logic                   i_reset,
  triangle_scheduler_if.slave         bus,
  input  wire logic                   i_clear_stats,
  output logic [$clog2(DEPTH):0]      o_level,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [15:0]                 o_tri_count,
  output logic [31:0]                 o_pixel_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [c_AW:0]   c_LEVEL_FULL = (c_AW + 1)'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_LAST   = c_CW'(BUSY_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_IDLE = 3'd3;
  localparam logic [2:0] S_COMPLETE  = 3'd4;

  logic [767:0]    r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]   r_level;
  logic [2:0]      r_state, w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [767:0]    r_tri;
  logic [15:0]     r_tri_count;
  logic [31:0]     r_pixel_count;

  logic w_full, w_push, w_pop, w_load, w_start, w_complete, w_done;

  assign w_full = (r_level == c_LEVEL_FULL);
  assign w_push = bus.i_tri_valid && bus.o_tri_ready;

  // Ready is held low while reset is asserted so the block presents all-zero outputs.
  assign bus.o_tri_ready = !w_full && !i_reset;

  // FIFO storage carries no reset; validity is tracked by r_level alone.
  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {bus.i_v1, bus.i_v2, bus.i_v3, bus.i_c1, bus.i_c2, bus.i_c3};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (c_AW + 1)'(1);
        2'b01:   r_level <= r_level - (c_AW + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if ((r_level != '0) && bus.i_rast_idle) w_state_nxt = S_ISSUE;
      S_ISSUE:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!bus.i_rast_idle)        w_state_nxt = S_WAIT_IDLE;
        else if (r_cnt == c_CNT_LAST) w_state_nxt = S_COMPLETE;
      end
      S_WAIT_IDLE: if (bus.i_rast_idle) w_state_nxt = S_COMPLETE;
      S_COMPLETE:  w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load     = (r_state == S_IDLE) && (w_state_nxt == S_ISSUE);
    w_start    = (r_state == S_ISSUE);
    w_pop      = (r_state == S_ISSUE);
    w_complete = (r_state == S_COMPLETE);
    w_done     = w_complete && (r_level == '0);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_tri <= '0;
    end else begin
      if (w_load)                       r_tri <= r_mem[r_rd_ptr];
      if (r_state == S_ISSUE)           r_cnt <= '0;
      else if (r_state == S_WAIT_BUSY)  r_cnt <= r_cnt + c_CW'(1);
    end
  end

  // Clear wins over a same-cycle increment; pixel count sticks at all-ones.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tri_count   <= '0;
      r_pixel_count <= '0;
    end else if (i_clear_stats) begin
      r_tri_count   <= '0;
      r_pixel_count <= '0;
    end else begin
      if (w_complete) r_tri_count <= r_tri_count + 16'd1;
      if (bus.i_rast_write && (r_pixel_count != 32'hFFFF_FFFF))
        r_pixel_count <= r_pixel_count + 32'd1;
    end
  end

  assign {bus.o_v1, bus.o_v2, bus.o_v3, bus.o_c1, bus.o_c2, bus.o_c3} = r_tri;
  assign bus.o_rast_start = w_start;
  assign o_done           = w_done;
  assign o_level          = r_level;
  assign o_busy           = (r_state != S_IDLE) || (r_level != '0);
  assign o_tri_count      = r_tri_count;
  assign o_pixel_count    = r_pixel_count;

endmodule

`default_nettype wire

// File: tb/tb_triangle_scheduler.sv
// tb_triangle_scheduler: directed self-checking bench for triangle_scheduler.
// Rev 1.0
`default_nettype none

module tb_triangle_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  level;
  logic        busy, done;
  logic [15:0] tri_count;
  logic [31:0] pix;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  triangle_scheduler_if bus ();

  triangle_scheduler #(.DEPTH(4), .BUSY_TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .bus          (bus),
    .i_clear_stats(clear),
    .o_level      (level),
    .o_busy       (busy),
    .o_done       (done),
    .o_tri_count  (tri_count),
    .o_pixel_count(pix)
  );

  // Rasterizer model: after a start it drops idle for busy_len cycles.
  int busy_len   = 20;
  int busy_cnt   = 0;
  bit force_busy = 1'b0;
  bit stuck_idle = 1'b0;

  always @(posedge clk) begin
    if (busy_cnt > 0)                            busy_cnt <= busy_cnt - 1;
    else if (bus.o_rast_start && !stuck_idle)    busy_cnt <= busy_len;
  end
  assign bus.i_rast_idle = !force_busy && (busy_cnt == 0);

  int           start_cnt, done_cnt, last_start_cyc, last_done_cyc;
  logic [127:0] start_v1_q[$];
  bit           prev_idle, idle_ok;

  always @(negedge clk) begin
    if (bus.o_rast_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      start_v1_q.push_back(bus.o_v1);
      if (!prev_idle) idle_ok = 1'b0;
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    prev_idle = bus.i_rast_idle;
  end

  function automatic logic [127:0] vec(input int x, input int y);
    return {32'h0001_0000, 32'd0, 32'(y) << 16, 32'(x) << 16};
  endfunction

  function automatic logic [127:0] exp_v1(input int id); return vec(id, 0);      endfunction
  function automatic logic [127:0] exp_v2(input int id); return vec(id + 8, 0);  endfunction
  function automatic logic [127:0] exp_v3(input int id); return vec(id, 8);      endfunction
  function automatic logic [127:0] exp_c1(input int id); return {4{32'(id) + 32'h100}}; endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tri(input int id);
    bus.i_v1 = exp_v1(id);
    bus.i_v2 = exp_v2(id);
    bus.i_v3 = exp_v3(id);
    bus.i_c1 = exp_c1(id);
    bus.i_c2 = {4{32'(id) + 32'h200}};
    bus.i_c3 = {4{32'(id) + 32'h300}};
  endtask

  task automatic clear_mon();
    start_cnt = 0;
    done_cnt  = 0;
    idle_ok   = 1'b1;
    start_v1_q.delete();
  endtask

  task automatic apply_reset();
    bus.i_tri_valid  = 1'b0;
    bus.i_rast_write = 1'b0;
    clear            = 1'b0;
    rst              = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    clear_mon();
  endtask

  task automatic wait_done(input int target, input string name);
    int w = 0;
    while (done_cnt < target && w < 300) begin
      tick();
      w++;
    end
    if (done_cnt < target) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: done pulses %0d required %0d", name, done_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++; if ({bus.o_tri_ready, bus.o_rast_start, busy, done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b required 0000", {bus.o_tri_ready, bus.o_rast_start, busy, done});
    end
    n_cmp++; if ({level, tri_count, pix} !== '0) begin
      n_err++; $display("FAIL reset_counts: level %0d tri %0d pix %0d required 0", level, tri_count, pix);
    end
    n_cmp++; if (bus.o_v1 !== 128'd0) begin
      n_err++; $display("FAIL reset_v1: got %h required 0", bus.o_v1);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.o_tri_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b required 1", bus.o_tri_ready);
    end
  endtask

  task automatic test_single();
    int k;
    apply_reset();
    busy_len = 20;
    set_tri(0);
    bus.i_tri_valid = 1'b1;
    k = cyc;
    tick();
    bus.i_tri_valid = 1'b0;
    n_cmp++; if (bus.o_rast_start !== 1'b0 || level !== 3'd1) begin
      n_err++; $display("FAIL single_t1: start %b level %0d required 0/1", bus.o_rast_start, level);
    end
    tick();
    n_cmp++; if (bus.o_rast_start !== 1'b1) begin
      n_err++; $display("FAIL single_start: got %b required 1", bus.o_rast_start);
    end
    n_cmp++; if ({bus.o_v1, bus.o_v2, bus.o_v3} !== {exp_v1(0), exp_v2(0), exp_v3(0)}) begin
      n_err++; $display("FAIL single_verts: got %h %h %h required %h %h %h", bus.o_v1, bus.o_v2, bus.o_v3,
                        exp_v1(0), exp_v2(0), exp_v3(0));
    end
    n_cmp++; if (bus.o_c1 !== exp_c1(0)) begin
      n_err++; $display("FAIL single_c1: got %h required %h", bus.o_c1, exp_c1(0));
    end
    wait_done(1, "single");
    repeat (5) tick();
    n_cmp++; if (last_done_cyc - k !== 24) begin
      n_err++; $display("FAIL single_done_cycle: got +%0d required +24", last_done_cyc - k);
    end
    n_cmp++; if (start_cnt !== 1 || done_cnt !== 1) begin
      n_err++; $display("FAIL single_pulses: starts %0d dones %0d required 1/1", start_cnt, done_cnt);
    end
    n_cmp++; if (tri_count !== 16'd1 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_end: tri %0d busy %b required 1/0", tri_count, busy);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    apply_reset();
    force_busy = 1'b1;
    busy_len   = 3;
    for (int i = 0; i < 4; i++) begin
      set_tri(i + 1);
      bus.i_tri_valid = 1'b1;
      n_cmp++; if (bus.o_tri_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_ready_%0d: got %b required 1", i, bus.o_tri_ready);
      end
      tick();
    end
    set_tri(5);
    n_cmp++; if (bus.o_tri_ready !== 1'b0 || level !== 3'd4) begin
      n_err++; $display("FAIL b2b_full: ready %b level %0d required 0/4", bus.o_tri_ready, level);
    end
    tick();
    tick();
    n_cmp++; if (level !== 3'd4 || start_cnt !== 0) begin
      n_err++; $display("FAIL b2b_hold: level %0d starts %0d required 4/0", level, start_cnt);
    end
    force_busy = 1'b0;
    w = 0;
    while (!bus.o_tri_ready && w < 20) begin
      tick();
      w++;
    end
    n_cmp++; if (bus.o_tri_ready !== 1'b1 || start_cnt !== 1) begin
      n_err++; $display("FAIL b2b_fifth_ready: ready %b starts %0d required 1/1", bus.o_tri_ready, start_cnt);
    end
    tick();
    bus.i_tri_valid = 1'b0;
    wait_done(1, "b2b");
    repeat (5) tick();
    n_cmp++; if (start_cnt !== 5 || start_v1_q.size() !== 5) begin
      n_err++; $display("FAIL b2b_starts: got %0d required 5", start_cnt);
    end
    for (int i = 0; i < start_v1_q.size(); i++) begin
      n_cmp++; if (start_v1_q[i] !== exp_v1(i + 1)) begin
        n_err++; $display("FAIL b2b_order_%0d: got %h required %h", i, start_v1_q[i], exp_v1(i + 1));
      end
    end
    n_cmp++; if (idle_ok !== 1'b1) begin
      n_err++; $display("FAIL b2b_idle_gate: got %b required 1", idle_ok);
    end
    n_cmp++; if (done_cnt !== 1 || tri_count !== 16'd5 || level !== 3'd0) begin
      n_err++; $display("FAIL b2b_end: dones %0d tri %0d level %0d required 1/5/0", done_cnt, tri_count, level);
    end
  endtask

  task automatic test_degenerate();
    int k;
    apply_reset();
    stuck_idle = 1'b1;
    set_tri(7);
    bus.i_tri_valid = 1'b1;
    k = cyc;
    tick();
    bus.i_tri_valid = 1'b0;
    tick();
    n_cmp++; if (bus.o_rast_start !== 1'b1) begin
      n_err++; $display("FAIL degen_start: got %b required 1", bus.o_rast_start);
    end
    wait_done(1, "degen");
    tick();
    n_cmp++; if (last_done_cyc - k !== 7 || tri_count !== 16'd1) begin
      n_err++; $display("FAIL degen_timeout: done +%0d tri %0d required +7/1", last_done_cyc - k, tri_count);
    end
    stuck_idle = 1'b0;
    busy_len   = 2;
    set_tri(8);
    bus.i_tri_valid = 1'b1;
    k = cyc;
    tick();
    bus.i_tri_valid = 1'b0;
    tick();
    n_cmp++; if (bus.o_rast_start !== 1'b1 || bus.o_v1 !== exp_v1(8)) begin
      n_err++; $display("FAIL degen_next_start: start %b v1 %h required 1/%h", bus.o_rast_start, bus.o_v1, exp_v1(8));
    end
    wait_done(2, "degen_next");
    tick();
    n_cmp++; if (last_done_cyc - k !== 6 || tri_count !== 16'd2) begin
      n_err++; $display("FAIL degen_next_done: done +%0d tri %0d required +6/2", last_done_cyc - k, tri_count);
    end
  endtask

  task automatic test_pixel();
    apply_reset();
    bus.i_rast_write = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      clear = (i == 5);
      tick();
      if (i == 4) begin
        n_cmp++; if (pix !== 32'd4) begin
          n_err++; $display("FAIL pix_pre_clear: got %0d required 4", pix);
        end
      end
    end
    bus.i_rast_write = 1'b0;
    clear = 1'b0;
    n_cmp++; if (pix !== 32'd5) begin
      n_err++; $display("FAIL pix_after_clear: got %0d required 5", pix);
    end
    dut.r_pixel_count = 32'hFFFF_FFFD;
    bus.i_rast_write = 1'b1;
    tick();
    n_cmp++; if (pix !== 32'hFFFF_FFFE) begin
      n_err++; $display("FAIL pix_near_max: got %h required FFFFFFFE", pix);
    end
    repeat (3) tick();
    bus.i_rast_write = 1'b0;
    n_cmp++; if (pix !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL pix_saturate: got %h required FFFFFFFF", pix);
    end
  endtask

  task automatic test_reset_mid();
    int s0, k;
    apply_reset();
    busy_len = 20;
    for (int i = 0; i < 3; i++) begin
      set_tri(10 + i);
      bus.i_tri_valid = 1'b1;
      tick();
    end
    bus.i_tri_valid = 1'b0;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b1 || level !== 3'd2 || bus.i_rast_idle !== 1'b0) begin
      n_err++; $display("FAIL mid_pre: busy %b level %0d idle %b required 1/2/0", busy, level, bus.i_rast_idle);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus.o_tri_ready, bus.o_rast_start, busy, done, level} !== '0 || bus.o_v1 !== 128'd0) begin
      n_err++; $display("FAIL mid_async: ready %b start %b busy %b done %b level %0d v1 %h required all 0",
                        bus.o_tri_ready, bus.o_rast_start, busy, done, level, bus.o_v1);
    end
    tick();
    rst = 1'b0;
    #1;
    s0 = start_cnt;
    repeat (30) tick();
    n_cmp++; if (start_cnt !== s0 || level !== 3'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_quiet: starts %0d level %0d busy %b required %0d/0/0", start_cnt, level, busy, s0);
    end
    set_tri(20);
    bus.i_tri_valid = 1'b1;
    k = cyc;
    tick();
    bus.i_tri_valid = 1'b0;
    tick();
    n_cmp++; if (bus.o_rast_start !== 1'b1 || bus.o_v1 !== exp_v1(20) || cyc - k !== 2) begin
      n_err++; $display("FAIL mid_restart: start %b v1 %h required 1/%h", bus.o_rast_start, bus.o_v1, exp_v1(20));
    end
    wait_done(1, "mid");
  endtask

  task automatic test_push_at_complete();
    apply_reset();
    busy_len = 2;
    set_tri(30);
    bus.i_tri_valid = 1'b1;
    tick();
    bus.i_tri_valid = 1'b0;
    repeat (5) tick();
    set_tri(31);
    bus.i_tri_valid = 1'b1;
    n_cmp++; if (done !== 1'b1) begin
      n_err++; $display("FAIL pac_done: got %b required 1", done);
    end
    tick();
    bus.i_tri_valid = 1'b0;
    n_cmp++; if (level !== 3'd1 || done !== 1'b0 || bus.o_rast_start !== 1'b0) begin
      n_err++; $display("FAIL pac_queued: level %0d done %b start %b required 1/0/0", level, done, bus.o_rast_start);
    end
    tick();
    n_cmp++; if (bus.o_rast_start !== 1'b1 || bus.o_v1 !== exp_v1(31)) begin
      n_err++; $display("FAIL pac_start: start %b v1 %h required 1/%h", bus.o_rast_start, bus.o_v1, exp_v1(31));
    end
    wait_done(2, "pac");
    tick();
    n_cmp++; if (tri_count !== 16'd2) begin
      n_err++; $display("FAIL pac_count: got %0d required 2", tri_count);
    end
  endtask

  initial begin
    bus.i_tri_valid  = 1'b0;
    bus.i_rast_write = 1'b0;
    set_tri(0);
    clear_mon();
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_degenerate();
    test_pixel();
    test_reset_mid();
    test_push_at_complete();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/triangle_scheduler.md
Name: triangle_scheduler

Overview:
Front-end controller for the triangle rasterizer. Buffers triangle commands (3 vertices + 3 colours) from the geometry stage in a small FIFO and issues them one at a time. It pulses the rasterizer's start only when the rasterizer reports idle, then tracks each triangle to completion. It also keeps pixel and triangle statistics and flags when all queued work has drained.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
BUSY_TIMEOUT, 4, max cycles to wait for rasterizer idle to fall after start before the triangle is treated as empty/degenerate.

Ports:
i_clk  in  1  clock.
i_reset  in  1  asynchronous, active-high reset.
i_tri_valid  in  1  triangle command valid.
o_tri_ready  out  1  FIFO can accept; equals !full.
i_v1, i_v2, i_v3  in  Vector4_t (128)  vertex positions, fixed point.
i_c1, i_c2, i_c3  in  Vector4_t (128)  vertex colours.
o_rast_start  out  1  one-cycle start to rasterizer.
o_v1, o_v2, o_v3, o_c1, o_c2, o_c3  out  Vector4_t (128)  triangle presented to rasterizer.
i_rast_idle  in  1  rasterizer idle.
i_rast_write  in  1  rasterizer pixel write strobe.
i_clear_stats  in  1  synchronous clear of counters.
o_level  out  $clog2(DEPTH)+1  FIFO occupancy.
o_busy  out  1  state != IDLE or FIFO non-empty.
o_done  out  1  one-cycle pulse: last queued triangle completed.
o_tri_count  out  16  triangles completed; wraps.
o_pixel_count  out  32  pixel writes; saturates at 0xFFFFFFFF.

Behaviour:
- Reset (async, i_reset=1): FIFO emptied, pointers/level 0, state IDLE, all outputs 0 including o_v*/o_c*; o_tri_ready=1 from the first cycle after release. Reset mid-triangle abandons it; the rasterizer itself is not reset by this block.
- FIFO: push on i_tri_valid && o_tri_ready. No bypass: a pushed entry is visible to the FSM the next cycle. When full, ready=0, so no push even if a pop occurs that cycle. Push and pop in the same non-full cycle leaves the level unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if level!=0 and i_rast_idle, register the FIFO head onto o_v*/o_c* and go to ISSUE.
  - ISSUE: o_rast_start=1 for exactly this cycle; pop head; o_v*/o_c* are held stable from ISSUE until the next load; counter=0; go to WAIT_BUSY.
  - WAIT_BUSY: if !i_rast_idle go to WAIT_IDLE; else if counter==BUSY_TIMEOUT-1 go to COMPLETE; else counter++.
  - WAIT_IDLE: when i_rast_idle go to COMPLETE.
  - COMPLETE: o_tri_count++; o_done=1 if level==0 at start of this cycle (a same-cycle push still yields done); go to IDLE.
- Latency: push at cycle T into an empty queue, FSM in IDLE, rasterizer idle: load at T+1, o_rast_start at T+2. Minimum spacing between starts is 5 cycles.
- o_pixel_count increments on each i_rast_write cycle in any state and saturates. i_clear_stats zeroes both counters and takes priority over a same-cycle increment. Clear does not affect the FIFO or FSM.
- o_busy and o_level are combinational from state and level.

Test Plan:
- Reset then single push (v1=(0,0), v2=(8,0), v3=(0,8)), i_rast_idle model low for 20 cycles after start -> o_rast_start exactly once, at push+2; o_v* equal input; one o_done pulse; o_tri_count=1.
- Push 5 back-to-back with DEPTH=4 and rasterizer busy -> o_tri_ready=0 after 4 accepted; 5th accepted after first pop; all 5 issued in order, each only when idle=1; o_done once, after the 5th.
- Degenerate triangle with i_rast_idle stuck 1 -> COMPLETE after BUSY_TIMEOUT (4) cycles in WAIT_BUSY; o_tri_count=1; next triangle issues normally.
- i_rast_write high for 10 cycles with i_clear_stats on cycle 5 -> o_pixel_count=5 at end; preset near 0xFFFFFFFF -> holds at 0xFFFFFFFF.
- Assert i_reset during WAIT_IDLE with 2 entries queued -> all outputs 0 asynchronously, o_level=0; after release no start until new push.
- Push in same cycle as COMPLETE of the last queued triangle -> o_done pulses; new triangle starts 2 cycles later.
